// File: rtl/write_back_pkg.sv
// Shared pipeline definitions for the write-back stage: CSR write selectors,
// load funct3 codes, FSM states and the registered write-port bundle.
package write_back_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CSR_AW = 12;

  typedef enum logic [2:0] {
    CSR_NONE  = 3'd0,
    CSR_ECALL = 3'd1,
    CSR_CSRRS = 3'd2,
    CSR_CSRRW = 3'd3
  } csr_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

  // What a pending load needs to remember while the data memory answers.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [2:0]        fmt;
    logic [1:0]        addr_lo;
  } load_ctx_t;

  typedef struct packed {
    logic              reg_wen;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   vald;
    logic [2:0]        csr_sel;
    logic [CSR_AW-1:0] csr_rd;
    logic [XLEN-1:0]   pc;
  } wb_port_t;

endpackage

// File: rtl/write_back_if.sv
// Memory-stage to write-back bundle: instruction handshake, load response,
// register/CSR write port and retire status.
interface write_back_if;
  import write_back_pkg::*;

  logic              mem_i_valid;
  logic              wb_o_ready;
  logic [XLEN-1:0]   mem_i_pc;
  logic              mem_i_reg_wen;
  logic [REG_AW-1:0] mem_i_rd;
  logic [XLEN-1:0]   mem_i_result;
  logic              mem_i_is_load;
  logic [2:0]        mem_i_load_fmt;
  logic [1:0]        mem_i_addr_lo;
  logic [2:0]        mem_i_csr_sel;
  logic [CSR_AW-1:0] mem_i_csr_rd;

  logic              dmem_i_rvalid;
  logic [XLEN-1:0]   dmem_i_rdata;

  logic              write_back_o_wb_reg_wen;
  logic [REG_AW-1:0] write_back_o_wb_rd;
  logic [XLEN-1:0]   write_back_o_wb_valD;
  logic [2:0]        write_back_o_wb_csr_sel;
  logic [CSR_AW-1:0] write_back_o_wb_csr_rd;
  logic [XLEN-1:0]   regW_o_pc;

  logic              write_back_o_commit;
  logic [63:0]       write_back_o_instret;
  logic              write_back_o_load_timeout;

  modport slave (
    input  mem_i_valid, mem_i_pc, mem_i_reg_wen, mem_i_rd, mem_i_result,
           mem_i_is_load, mem_i_load_fmt, mem_i_addr_lo, mem_i_csr_sel,
           mem_i_csr_rd, dmem_i_rvalid, dmem_i_rdata,
    output wb_o_ready, write_back_o_wb_reg_wen, write_back_o_wb_rd,
           write_back_o_wb_valD, write_back_o_wb_csr_sel, write_back_o_wb_csr_rd,
           regW_o_pc, write_back_o_commit, write_back_o_instret,
           write_back_o_load_timeout
  );

  modport master (
    output mem_i_valid, mem_i_pc, mem_i_reg_wen, mem_i_rd, mem_i_result,
           mem_i_is_load, mem_i_load_fmt, mem_i_addr_lo, mem_i_csr_sel,
           mem_i_csr_rd, dmem_i_rvalid, dmem_i_rdata,
    input  wb_o_ready, write_back_o_wb_reg_wen, write_back_o_wb_rd,
           write_back_o_wb_valD, write_back_o_wb_csr_sel, write_back_o_wb_csr_rd,
           regW_o_pc, write_back_o_commit, write_back_o_instret,
           write_back_o_load_timeout
  );

endinterface

// File: rtl/write_back_load_ext.sv
// Load data alignment and sign/zero extension for lb/lbu/lh/lhu/lw.
module load_ext
  import write_back_pkg::*;
(
  input  logic [2:0]      fmt,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = rdata[16*gi +: 16];
    end
  endgenerate

  // Halfword lane picks on addr_lo[1] only; misaligned low bit is ignored.
  assign sel_byte = byte_lane[addr_lo];
  assign sel_half = half_lane[addr_lo[1]];

  always_comb begin
    value = rdata;
    case (fmt)
      F3_LB:   value = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  value = {24'd0, sel_byte};
      F3_LH:   value = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  value = {16'd0, sel_half};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: registers ALU/CSR results or waits for load data,
// drives the regfile/CSR write port for one cycle per retired instruction.
module write_back
  import write_back_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
)(
  input  logic         clk,
  input  logic         rst,
  write_back_if.slave  bus
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  load_ctx_t        ctx_reg, ctx_next;
  wb_port_t         port_reg, port_next;
  logic             commit_reg, commit_next;
  logic [63:0]      instret_reg, instret_next;
  logic             timeout_reg, timeout_next;
  logic [XLEN-1:0]  load_val;

  load_ext u_load_ext (
    .fmt     (ctx_reg.fmt),
    .addr_lo (ctx_reg.addr_lo),
    .rdata   (bus.dmem_i_rdata),
    .value   (load_val)
  );

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    ctx_next          = ctx_reg;
    port_next         = port_reg;
    port_next.reg_wen = 1'b0;
    port_next.csr_sel = CSR_NONE;
    commit_next       = 1'b0;
    timeout_next      = timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        // A load response seen here is stale and deliberately ignored.
        if (bus.mem_i_valid) begin
          if (bus.mem_i_is_load) begin
            ctx_next.rd      = bus.mem_i_rd;
            ctx_next.pc      = bus.mem_i_pc;
            ctx_next.fmt     = bus.mem_i_load_fmt;
            ctx_next.addr_lo = bus.mem_i_addr_lo;
            cnt_next         = '0;
            state_next       = ST_LOAD_WAIT;
          end else begin
            port_next.reg_wen = bus.mem_i_reg_wen & (bus.mem_i_rd != '0);
            port_next.rd      = bus.mem_i_rd;
            port_next.vald    = bus.mem_i_result;
            port_next.csr_sel = bus.mem_i_csr_sel;
            port_next.csr_rd  = bus.mem_i_csr_rd;
            port_next.pc      = bus.mem_i_pc;
            commit_next       = 1'b1;
          end
        end
      end

      ST_LOAD_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (bus.dmem_i_rvalid) begin
          port_next.reg_wen = (ctx_reg.rd != '0);
          port_next.rd      = ctx_reg.rd;
          port_next.vald    = load_val;
          port_next.pc      = ctx_reg.pc;
          commit_next       = 1'b1;
          state_next        = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    instret_next = instret_reg + {63'd0, commit_next};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      ctx_reg     <= '0;
      port_reg    <= '0;
      commit_reg  <= 1'b0;
      instret_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ctx_reg     <= ctx_next;
      port_reg    <= port_next;
      commit_reg  <= commit_next;
      instret_reg <= instret_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.wb_o_ready                = (state_reg == ST_IDLE);
  assign bus.write_back_o_wb_reg_wen   = port_reg.reg_wen;
  assign bus.write_back_o_wb_rd        = port_reg.rd;
  assign bus.write_back_o_wb_valD      = port_reg.vald;
  assign bus.write_back_o_wb_csr_sel   = port_reg.csr_sel;
  assign bus.write_back_o_wb_csr_rd    = port_reg.csr_rd;
  assign bus.regW_o_pc                 = port_reg.pc;
  assign bus.write_back_o_commit       = commit_reg;
  assign bus.write_back_o_instret      = instret_reg;
  assign bus.write_back_o_load_timeout = timeout_reg;

endmodule
